// File: rtl/pwm_adc_sar.sv
// PWM-referenced ADC controller: sweep or SAR search against an external comparator.
// Define PWM_ADC_CONT_EN for back-to-back continuous conversions while enabled.
module pwm_adc_sar #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = (2**WIDTH)*40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             mode,
  input  logic             comp_result,
  output logic             compare_neg_pwm,
  output logic             busy,
  output logic             drdy_out,
  output logic [WIDTH-1:0] data_out
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] CODE_MAX = '1;
  localparam logic [WIDTH-1:0] CODE_MSB = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    RELOAD   = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, DECIDE, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] duty;
  logic [WIDTH-1:0] pwm_cnt;
  logic [CW-1:0]    settle_cnt;
  logic [BW-1:0]    bit_idx;
  logic             mode_q;
  logic [1:0]       sync;

  logic             comp_sync;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] sar_code;
  logic [WIDTH-1:0] sweep_code;
  logic [WIDTH-1:0] result_code;
  logic [WIDTH-1:0] next_duty;
  logic             done_now;

  assign comp_sync = sync[1];

  // Search rule evaluated in DECIDE; duty holds the current trial code.
  always_comb begin
    bit_mask    = WIDTH'(1) << bit_idx;
    sar_code    = comp_sync ? duty : (duty & ~bit_mask);
    sweep_code  = comp_sync ? CODE_MAX : ((duty == '0) ? '0 : duty - 1'b1);
    result_code = mode_q ? sar_code : sweep_code;
    next_duty   = mode_q ? (sar_code | (bit_mask >> 1)) : (duty + 1'b1);
    done_now    = mode_q ? (bit_idx == '0) : (!comp_sync || duty == CODE_MAX);
  end

  // NOTE: every register here uses <= so all state updates together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      duty            <= '0;
      pwm_cnt         <= '0;
      settle_cnt      <= '0;
      bit_idx         <= '0;
      mode_q          <= 1'b0;
      sync            <= '0;
      compare_neg_pwm <= 1'b0;
      busy            <= 1'b0;
      drdy_out        <= 1'b0;
      data_out        <= '0;
    end else begin
      sync     <= {sync[0], comp_result};
      drdy_out <= 1'b0;
      if (!enable) begin
        pwm_cnt         <= '0;
        compare_neg_pwm <= 1'b0;
        state           <= IDLE;
        busy            <= 1'b0;
        duty            <= '0;
      end else begin
        pwm_cnt         <= pwm_cnt + 1'b1;
        compare_neg_pwm <= (pwm_cnt < duty);
        case (state)
          IDLE: begin
            if (start) begin
              mode_q     <= mode;
              duty       <= mode ? CODE_MSB : '0;
              bit_idx    <= BW'(WIDTH - 1);
              settle_cnt <= RELOAD;
              busy       <= 1'b1;
              state      <= SETTLE;
            end
          end
          SETTLE: begin
            if (settle_cnt == '0) state <= DECIDE;
            else                  settle_cnt <= settle_cnt - 1'b1;
          end
          DECIDE: begin
            if (done_now) begin
              data_out <= result_code;
              drdy_out <= 1'b1;
              state    <= DONE;
`ifndef PWM_ADC_CONT_EN
              busy     <= 1'b0;
              duty     <= '0;
`endif
            end else begin
              duty       <= next_duty;
              settle_cnt <= RELOAD;
              if (mode_q) bit_idx <= bit_idx - 1'b1;
              state      <= SETTLE;
            end
          end
          DONE: begin
`ifdef PWM_ADC_CONT_EN
            // DONE doubles as the first settle cycle so conversions repeat at the fixed period.
            mode_q  <= mode;
            duty    <= mode ? CODE_MSB : '0;
            bit_idx <= BW'(WIDTH - 1);
            if (SETTLE_CYCLES > 1) begin
              settle_cnt <= CW'(SETTLE_CYCLES - 2);
              state      <= SETTLE;
            end else begin
              state      <= DECIDE;
            end
`else
            state <= IDLE;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/pwm_adc_sar.md
# pwm_adc_sar

Parametrised PWM-referenced ADC controller with run-time selectable linear-sweep or successive-approximation (SAR) search. It generates the comparator reference PWM, waits a settling period per trial, samples an external comparator, and publishes a WIDTH-bit code with a one-cycle data-ready pulse. It sits between the analog front end (RC-filtered PWM into an off-chip comparator) and the MIDI-player control logic that consumes samples.

## Interface
- WIDTH, 8: code width and PWM resolution; legal range 2..16.
- SETTLE_CYCLES, (2**WIDTH)*40: clocks per trial for reference settling; must be ≥1.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  block enable; low aborts any conversion and idles the PWM.
- start  in  1  single-cycle conversion request.
- mode  in  1  0 = sweep, 1 = SAR; sampled on accepted start.
- comp_result  in  1  asynchronous comparator output; 1 = input ≥ reference.
- compare_neg_pwm  out  1  PWM reference to the RC filter.
- busy  out  1  conversion in progress.
- drdy_out  out  1  one-cycle pulse, data_out valid.
- data_out  out  WIDTH  last completed code, held until the next completion.

## Operation
- Reset values: compare_neg_pwm=0, busy=0, drdy_out=0, data_out=0; state IDLE, duty=0, PWM counter=0, sync flops=0.
- PWM: free-running WIDTH-bit counter while enable=1; compare_neg_pwm = (cnt < duty), registered. duty=0 gives constant low. enable=0 clears the counter and forces the output low.
- comp_result passes through a 2-flop synchroniser; decisions use only the synchronised value.
- States: IDLE, SETTLE, DECIDE, DONE.
  - IDLE: on start=1 and enable=1, latch mode, go to SETTLE, load the settle counter with SETTLE_CYCLES-1, set the first trial duty (sweep: 0; SAR: MSB only), set busy=1.
  - SETTLE: count down. At 0, go to DECIDE.
  - DECIDE: one cycle. Apply the search rule. Then either go to DONE, or set the next trial duty, reload the counter and return to SETTLE.
  - DONE: data_out ← result, drdy_out=1 for this cycle only, busy=0, duty ← 0, go to IDLE.
- Sweep rule, trial d:
  - comp=1 and d=max: result=max.
  - comp=1: next trial d+1.
  - comp=0: result = (d==0) ? 0 : d-1.
- SAR rule, bit b from MSB to LSB:
  - comp=1 keeps bit b; comp=0 clears it.
  - If b is not the LSB, the next trial sets bit b-1.
  - After the LSB decision, result = accumulated code.
- Both modes report the largest code with input ≥ reference.
- Boundary behaviour:
  - start while busy: ignored. mode changes mid-conversion: ignored.
  - enable falls mid-conversion: next cycle is IDLE with busy=0 and no drdy_out; data_out is unchanged.
  - reset mid-conversion: all registers return to their reset values next cycle.
  - No arithmetic wrap: sweep terminates at max, and d-1 is guarded at 0.

## Timing
- Accepted start at cycle 0. busy=1 and SETTLE from cycle 1.
- Each trial takes SETTLE_CYCLES+1 clocks (SETTLE plus DECIDE).
- SAR: drdy_out at cycle 1 + WIDTH·(SETTLE_CYCLES+1). Fixed latency.
- Sweep: T = code+2 trials for code < max, T = 2^WIDTH for code = max. drdy_out at cycle 1 + T·(SETTLE_CYCLES+1).
- busy falls in the DONE cycle. A new start is accepted the cycle after DONE.
- data_out changes only in the drdy_out cycle.
- The synchroniser adds 2 cycles; SETTLE_CYCLES ≥ 3 is required for the decision to reflect the current trial.

## Configuration
- PWM_ADC_CONT_EN defined: while enable=1, DONE returns directly to SETTLE with a new first trial, using the mode input sampled at that point. Conversions repeat back-to-back; start is ignored and busy stays 1.
- PWM_ADC_CONT_EN undefined: one conversion per accepted start.

## Test plan
Bench setup: WIDTH=4, SETTLE_CYCLES=4. Comparator model: comp_result = (vin ≥ duty), where duty is the PWM duty.
- SAR, vin=9, start at cycle 0 → busy=1 at cycle 1; drdy_out at cycle 21 with data_out=9; busy=0 at cycle 21.
- Sweep, vin=5 → 7 trials; drdy_out at cycle 36 with data_out=5. Sweep, vin=15 → drdy_out at cycle 81 with data_out=15.
- SAR vin=0 → data_out=0. Sweep vin=0 → 2 trials, drdy_out at cycle 11, data_out=0.
- Start pulses at cycles 5 and 10 during busy → no effect; exactly one drdy_out.
- enable=0 at cycle 8 of a SAR run → busy=0 at cycle 9, no drdy_out, data_out keeps its previous value, compare_neg_pwm=0. Separate run: reset at cycle 8 → all outputs 0 at cycle 9.
- With PWM_ADC_CONT_EN, SAR, vin=12, enable held high → drdy_out every 20 cycles after the first, each with data_out=12.
